// File: rtl/datapath_sequencer_pkg.sv
// Shared types and field layout for the datapath command sequencer.
package datapath_sequencer_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 32;
  localparam int unsigned DATA_W = 32;

  // Command entry layout, LSB first: wb, use_imm, imm, rd, rs2, rs1, op
  localparam int unsigned WB_LSB      = 0;
  localparam int unsigned USE_IMM_LSB = 1;
  localparam int unsigned IMM_LSB     = 2;
  localparam int unsigned RD_LSB      = IMM_LSB + IMM_W;
  localparam int unsigned RS2_LSB     = RD_LSB + REG_W;
  localparam int unsigned RS1_LSB     = RS2_LSB + REG_W;
  localparam int unsigned OP_LSB      = RS1_LSB + REG_W;
  localparam int unsigned ENTRY_W     = OP_LSB + OP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             use_imm;
    logic             wb;
  } cmd_entry_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Command, datapath-control and response signals of the sequencer.
interface datapath_sequencer_if
  import datapath_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [REG_W-1:0]  cmd_rs1;
  logic [REG_W-1:0]  cmd_rs2;
  logic [REG_W-1:0]  cmd_rd;
  logic [IMM_W-1:0]  cmd_imm;
  logic              cmd_use_imm;
  logic              cmd_wb;

  logic [OP_W-1:0]   dp_op;
  logic [REG_W-1:0]  dp_addr_a;
  logic [REG_W-1:0]  dp_addr_b;
  logic [REG_W-1:0]  dp_addr_d;
  logic [IMM_W-1:0]  dp_immed;
  logic              dp_y_sel;
  logic              dp_write;
  logic [DATA_W-1:0] dp_w;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [REG_W-1:0]  resp_rd;

  logic              busy;
  logic [CNT_W-1:0]  retired;

  // Issuer / datapath / consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm, cmd_use_imm, cmd_wb,
    output dp_w, resp_ready,
    input  cmd_ready, dp_op, dp_addr_a, dp_addr_b, dp_addr_d, dp_immed, dp_y_sel, dp_write,
    input  resp_valid, resp_data, resp_rd, busy, retired
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm, cmd_use_imm, cmd_wb,
    input  dp_w, resp_ready,
    output cmd_ready, dp_op, dp_addr_a, dp_addr_b, dp_addr_d, dp_immed, dp_y_sel, dp_write,
    output resp_valid, resp_data, resp_rd, busy, retired
  );

endinterface

// File: rtl/datapath_sequencer_seq_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO; extra pointer bit separates full from empty.
module seq_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 56
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic                    full,
  output logic                    empty,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_push_ok;
  logic               w_pop_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                 (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign count = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage carries no reset; contents are only visible through a valid read pointer
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Queues ALU commands, drives the datapath controls for one at a time and returns each result.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  datapath_sequencer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  state_e              r_state;
  state_e              w_state_nxt;

  cmd_entry_t          w_entry;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_full;
  logic                w_empty;
  logic [PTR_W:0]      w_count;
  logic [PTR_W:0]      w_count_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_hs;
  logic                w_dp_write_nxt;
  logic                w_resp_valid_nxt;
  logic                w_busy_nxt;

  logic [OP_W-1:0]     r_dp_op;
  logic [REG_W-1:0]    r_dp_addr_a;
  logic [REG_W-1:0]    r_dp_addr_b;
  logic [REG_W-1:0]    r_dp_addr_d;
  logic [IMM_W-1:0]    r_dp_immed;
  logic                r_dp_y_sel;
  logic                r_dp_write;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [REG_W-1:0]    r_resp_rd;
  logic                r_busy;
  logic [CNT_W-1:0]    r_retired;

  always_comb begin
    w_entry         = '0;
    w_entry.op      = bus.cmd_op;
    w_entry.rs1     = bus.cmd_rs1;
    w_entry.rs2     = bus.cmd_rs2;
    w_entry.rd      = bus.cmd_rd;
    w_entry.imm     = bus.cmd_imm;
    w_entry.use_imm = bus.cmd_use_imm;
    w_entry.wb      = bus.cmd_wb;
  end

  assign w_push = bus.cmd_valid & ~w_full;
  assign w_hs   = r_resp_valid & bus.resp_ready;

  seq_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_entry),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, pop decision and next values of the registered status outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_dp_write_nxt   = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_count_nxt      = w_count;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_hs) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_EXEC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // x0 is hard-wired zero in the bank, so writes to it are never issued
    w_dp_write_nxt   = w_pop & w_head[WB_LSB] & (w_head[RD_LSB +: REG_W] != '0);
    w_resp_valid_nxt = (w_state_nxt == ST_RESP);
    w_count_nxt      = w_count + CNT_FW'(w_push) - CNT_FW'(w_pop);
    w_busy_nxt       = (w_count_nxt != '0) || (w_state_nxt != ST_IDLE);
  end

  // Datapath control fields are loaded on pop and otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dp_op     <= '0;
      r_dp_addr_a <= '0;
      r_dp_addr_b <= '0;
      r_dp_addr_d <= '0;
      r_dp_immed  <= '0;
      r_dp_y_sel  <= 1'b0;
      r_dp_write  <= 1'b0;
    end else begin
      r_dp_write <= w_dp_write_nxt;
      if (w_pop) begin
        r_dp_op     <= w_head[OP_LSB  +: OP_W];
        r_dp_addr_a <= w_head[RS1_LSB +: REG_W];
        r_dp_addr_b <= w_head[RS2_LSB +: REG_W];
        r_dp_addr_d <= w_head[RD_LSB  +: REG_W];
        r_dp_immed  <= w_head[IMM_LSB +: IMM_W];
        r_dp_y_sel  <= ~w_head[USE_IMM_LSB];
      end
    end
  end

  // Response capture at the end of EXEC, retire counter and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_busy       <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_resp_valid <= w_resp_valid_nxt;
      r_busy       <= w_busy_nxt;
      if (r_state == ST_EXEC) begin
        r_resp_data <= bus.dp_w;
        r_resp_rd   <= r_dp_addr_d;
      end
      if (w_hs) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.cmd_ready  = ~w_full;
  assign bus.dp_op      = r_dp_op;
  assign bus.dp_addr_a  = r_dp_addr_a;
  assign bus.dp_addr_b  = r_dp_addr_b;
  assign bus.dp_addr_d  = r_dp_addr_d;
  assign bus.dp_immed   = r_dp_immed;
  assign bus.dp_y_sel   = r_dp_y_sel;
  assign bus.dp_write   = r_dp_write;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_rd    = r_resp_rd;
  assign bus.busy       = r_busy;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: register-bank/ALU harness, in-order response model, directed tests.
module tb_datapath_sequencer;
  import datapath_sequencer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;
  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_XOR = 7'h04;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datapath_sequencer_if #(.CNT_W(CNT_W)) bus();

  datapath_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] alu(input logic [6:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_XOR:  return x ^ y;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event seen with no expected entry (t=%0t)", name, $time);
  endtask

  // Datapath harness: 32x32 bank with combinational reads and x0 tied to zero
  logic [31:0] h_rf [32];
  assign bus.dp_w = alu(bus.dp_op, h_rf[bus.dp_addr_a],
                        bus.dp_y_sel ? h_rf[bus.dp_addr_b] : bus.dp_immed);
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) h_rf[i] <= 32'h0;
    end else if (bus.dp_write && bus.dp_addr_d != 5'd0) begin
      h_rf[bus.dp_addr_d] <= bus.dp_w;
    end
  end

  // Program-order model: each accepted command's result computed at acceptance
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic        use_imm;
    logic        wr;
  } exp_t;

  exp_t        q[$];
  exp_t        e_new;
  logic [31:0] m_rf [32];
  int          m_out = 0;
  int          m_retired = 0;
  int          m_pulses = 0;
  int          o_pulses = 0;

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      m_out = 0;
      m_retired = 0;
      m_pulses = 0;
      o_pulses = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      chk("busy", 64'(bus.busy), 64'(m_out != 0));
      chk("retired", 64'(bus.retired), 64'(m_retired));
      if (bus.resp_valid) begin
        if (q.size() == 0) fail_evt("resp_valid");
        else begin
          chk("resp_data", 64'(bus.resp_data), 64'(q[0].data));
          chk("resp_rd", 64'(bus.resp_rd), 64'(q[0].rd));
        end
      end
      if (bus.dp_write) begin
        o_pulses++;
        if (q.size() == 0) fail_evt("dp_write");
        else begin
          chk("dp_write", 64'(bus.dp_write), 64'(q[0].wr));
          chk("dp_addr_d", 64'(bus.dp_addr_d), 64'(q[0].rd));
          chk("dp_op", 64'(bus.dp_op), 64'(q[0].op));
          chk("dp_y_sel", 64'(bus.dp_y_sel), 64'(!q[0].use_imm));
        end
      end
      // events taking effect at the coming rising edge
      if (bus.resp_valid && bus.resp_ready && q.size() != 0) begin
        if (q[0].wr) m_pulses++;
        void'(q.pop_front());
        m_out--;
        m_retired++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        e_new.data    = alu(bus.cmd_op, m_rf[bus.cmd_rs1],
                            bus.cmd_use_imm ? bus.cmd_imm : m_rf[bus.cmd_rs2]);
        e_new.rd      = bus.cmd_rd;
        e_new.op      = bus.cmd_op;
        e_new.use_imm = bus.cmd_use_imm;
        e_new.wr      = bus.cmd_wb && (bus.cmd_rd != 5'd0);
        if (e_new.wr) m_rf[bus.cmd_rd] = e_new.data;
        q.push_back(e_new);
        m_out++;
      end
    end
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic use_imm,
                      input logic wb);
    int t;
    bus.cmd_op = op; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_rd = rd;
    bus.cmd_imm = imm; bus.cmd_use_imm = use_imm; bus.cmd_wb = wb;
    bus.cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic [4:0] rd);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.resp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("resp_arrives", 64'(bus.resp_valid), 64'(1));
    d  = bus.resp_data;
    rd = bus.resp_rd;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    bus.resp_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_idle", 64'(bus.busy), 64'(0));
    chk("write_pulses", 64'(o_pulses), 64'(m_pulses));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  r;
    int          p0;
    int          prev_cyc;

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.cmd_rd = '0; bus.cmd_imm = '0; bus.cmd_use_imm = 1'b0; bus.cmd_wb = 1'b0;
    bus.resp_ready = 1'b1;

    // Test 1: reset asserted mid-cycle while a command is offered
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_op = OP_ADD; bus.cmd_rd = 5'd7; bus.cmd_imm = 32'd55;
    bus.cmd_use_imm = 1'b1; bus.cmd_wb = 1'b1; bus.cmd_valid = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t1_dp_write", 64'(bus.dp_write), 64'(0));
    chk("t1_dp_fields", 64'({bus.dp_op, bus.dp_addr_a, bus.dp_addr_b, bus.dp_addr_d, bus.dp_y_sel}), 64'(0));
    chk("t1_dp_immed", 64'(bus.dp_immed), 64'(0));
    chk("t1_resp", 64'({bus.resp_valid, bus.resp_rd}), 64'(0));
    chk("t1_resp_data", 64'(bus.resp_data), 64'(0));
    chk("t1_busy_retired", 64'({bus.busy, bus.retired}), 64'(0));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t1_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_no_write", 64'(bus.dp_write), 64'(0));
      chk("t1_idle", 64'(bus.busy), 64'(0));
    end
    @(posedge clk);
    #1;

    // Test 2: ADD immediate with cycle-exact timing, then readback
    send(OP_ADD, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1);
    drain();
    send(OP_ADD, 5'd1, 5'd0, 5'd3, 32'd7, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_c0_write", 64'(bus.dp_write), 64'(0));
    chk("t2_c0_valid", 64'(bus.resp_valid), 64'(0));
    @(negedge clk);
    chk("t2_c1_write", 64'(bus.dp_write), 64'(1));
    chk("t2_c1_ysel", 64'(bus.dp_y_sel), 64'(0));
    chk("t2_c1_addr_d", 64'(bus.dp_addr_d), 64'(3));
    @(negedge clk);
    chk("t2_c2_write", 64'(bus.dp_write), 64'(0));
    chk("t2_c2_valid", 64'(bus.resp_valid), 64'(1));
    chk("t2_c2_data", 64'(bus.resp_data), 64'(12));
    chk("t2_c2_rd", 64'(bus.resp_rd), 64'(3));
    @(posedge clk);
    #1;
    drain();
    send(OP_ADD, 5'd3, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0);
    wait_resp(d, r);
    chk("t2_readback", 64'(d), 64'(12));
    drain();

    // Test 3: write to x0 is suppressed, result still returned
    p0 = o_pulses;
    send(OP_ADD, 5'd1, 5'd0, 5'd0, 32'd100, 1'b1, 1'b1);
    wait_resp(d, r);
    chk("t3_data", 64'(d), 64'(105));
    chk("t3_rd", 64'(r), 64'(0));
    drain();
    chk("t3_no_pulse", 64'(o_pulses), 64'(p0));

    // Test 4: fill FIFO under backpressure, then release
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send(OP_ADD, 5'd0, 5'd0, 5'(k + 1), 32'(10 * (k + 1)), 1'b1, 1'b1);
    bus.cmd_op = OP_ADD; bus.cmd_rs1 = 5'd0; bus.cmd_rd = 5'd9;
    bus.cmd_imm = 32'd999; bus.cmd_use_imm = 1'b1; bus.cmd_wb = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    chk("t4_full", 64'(bus.cmd_ready), 64'(0));
    @(negedge clk);
    chk("t4_still_full", 64'(bus.cmd_ready), 64'(0));
    chk("t4_held_valid", 64'(bus.resp_valid), 64'(1));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bus.resp_ready = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_resp(d, r);
      chk("t4_order_rd", 64'(r), 64'(k + 1));
      chk("t4_order_data", 64'(d), 64'(10 * (k + 1)));
      if (k > 0) chk("t4_spacing", 64'(cyc - prev_cyc), 64'(2));
      prev_cyc = cyc;
    end
    @(negedge clk);
    chk("t4_busy_done", 64'(bus.busy), 64'(0));
    chk("t4_retired", 64'(bus.retired), 64'(9));
    @(posedge clk);
    #1;
    drain();

    // Test 5: register-register SUB selects reg B
    send(OP_ADD, 5'd0, 5'd0, 5'd1, 32'd9, 1'b1, 1'b1);
    send(OP_ADD, 5'd0, 5'd0, 5'd2, 32'd4, 1'b1, 1'b1);
    drain();
    send(OP_SUB, 5'd1, 5'd2, 5'd5, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_write", 64'(bus.dp_write), 64'(1));
    chk("t5_ysel", 64'(bus.dp_y_sel), 64'(1));
    @(negedge clk);
    chk("t5_valid", 64'(bus.resp_valid), 64'(1));
    chk("t5_data", 64'(bus.resp_data), 64'(5));
    @(posedge clk);
    #1;
    send(OP_XOR, 5'd5, 5'd0, 5'd0, 32'd3, 1'b1, 1'b0);
    wait_resp(d, r);
    chk("t5_readback", 64'(d), 64'(6));
    drain();

    // Test 6: reset during EXEC with three commands queued
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send(OP_ADD, 5'd0, 5'd0, 5'(k + 1), 32'(k + 1), 1'b1, 1'b1);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_in_exec", 64'(bus.dp_write), 64'(1));
    #1 reset = 1'b0;
    #1 chk("t6_write_drop", 64'(bus.dp_write), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_resp", 64'({bus.resp_valid, bus.dp_write, bus.busy}), 64'(0));
    end
    chk("t6_retired", 64'(bus.retired), 64'(0));
    chk("t6_ready", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    send(OP_ADD, 5'd0, 5'd0, 5'd0, 32'd77, 1'b1, 1'b0);
    wait_resp(d, r);
    chk("t6_fresh_data", 64'(d), 64'(77));
    drain();
    chk("t6_retired_after", 64'(bus.retired), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
